conv_encoder_core: RTL and testbench

- Rate-1/n convolutional encoder that produces the 24-bit softbit words consumed by viterbi_core from its input buffer.
- Reads info bits from a byte-wide source SRAM and encodes them with the same register_num/polynomial/tail-biting configuration the decoder uses.
- Writes one mapped softbit word per trellis step into a 24x4096 buffer.
- Used as the frame generator for decoder loopback benches and as the TX-path encoder.

---
 rtl/viterbi_pkg.sv | 28 ++
 rtl/conv_enc_parity.sv | 21 ++
 rtl/conv_encoder_core.sv | 184 ++++++++++++++++++
 tb/tb_conv_encoder_core.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and config decode helpers for the
// convolutional encoder that feeds viterbi_core.
package viterbi_pkg;

  localparam int MAX_M = 6;
  localparam int MAX_P = 6;

  localparam logic [3:0] SOFT_P7 = 4'b0111;
  localparam logic [3:0] SOFT_M7 = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_BIT,
    S_TAIL,
    S_DONE
  } enc_state_e;

  function automatic logic [2:0] decode_m(input logic [1:0] register_num);
    return 3'd6 - {1'b0, register_num};
  endfunction

  function automatic logic [2:0] decode_p(input logic [2:0] valid_polynomials);
    return (valid_polynomials > 3'd4) ? 3'd6 : valid_polynomials + 3'd2;
  endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity/softbit mapper: one 4-bit lane per active generator
// polynomial, unused lanes forced to zero.
module conv_enc_parity
  import viterbi_pkg::*;
(
  input  logic [MAX_M:0]          w,
  input  logic [2:0]              p_cnt,
  input  logic [MAX_P-1:0][7:0]   polys,
  output logic [4*MAX_P-1:0]      word
);

  always_comb begin
    word = '0;
    for (int j = 0; j < MAX_P; j++) begin
      if (3'(j) < p_cnt) begin
        word[4*j +: 4] = (^(polys[j] & {1'b0, w})) ? SOFT_M7 : SOFT_P7;
      end
    end
  end

endmodule

// File: rtl/conv_encoder_core.sv
// Rate-1/n convolutional encoder: reads info bytes from a source SRAM and
// writes one mapped softbit word per trellis step into the decoder buffer.
module conv_encoder_core
  import viterbi_pkg::*;
#(
  parameter int SRC_ADDR_W = 12,
  parameter int DST_ADDR_W = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_an_i,
  input  logic                  rst_sync_i,
  input  logic                  frame_start_i,
  input  logic [1:0]            register_num_i,
  input  logic [2:0]            valid_polynomials_i,
  input  logic                  tail_biting_en_i,
  input  logic [7:0]            polynomial1_i,
  input  logic [7:0]            polynomial2_i,
  input  logic [7:0]            polynomial3_i,
  input  logic [7:0]            polynomial4_i,
  input  logic [7:0]            polynomial5_i,
  input  logic [7:0]            polynomial6_i,
  input  logic [11:0]           infobit_length_i,
  input  logic [SRC_ADDR_W-1:0] src_start_addr_i,
  input  logic [DST_ADDR_W-1:0] dst_start_addr_i,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  src_rd_o,
  output logic [SRC_ADDR_W-1:0] src_addr_o,
  input  logic [7:0]            src_rdata_i,
  output logic                  dst_wr_o,
  output logic [DST_ADDR_W-1:0] dst_addr_o,
  output logic [23:0]           dst_wdata_o,
  output enc_state_e            state_o
);

  typedef struct packed {
    logic [2:0]            m;
    logic [2:0]            p;
    logic                  tb;
    logic [MAX_P-1:0][7:0] polys;
    logic [11:0]           len;
    logic [SRC_ADDR_W-1:0] src_start;
  } cfg_t;

  typedef struct packed {
    logic [SRC_ADDR_W-1:0] src_addr;
    logic [DST_ADDR_W-1:0] dst_addr;
    logic [11:0]           bits_left;
    logic [2:0]            bit_idx;
    logic [7:0]            byte_val;
    logic [MAX_M-1:0]      sreg;
    logic [2:0]            tail_left;
    logic                  prime;
  } dp_t;

  enc_state_e state_q, state_d;
  cfg_t       cfg_q, cfg_d;
  dp_t        dp_q, dp_d;

  logic               cur_bit;
  logic [MAX_M:0]     cur_vec;
  logic [MAX_M:0]     w;
  logic [23:0]        par_word;

  // sreg[M-1] is the most recent past input; the current bit lands at w[M].
  always_comb begin
    cur_bit = (state_q == S_BIT) ? dp_q.byte_val[dp_q.bit_idx] : 1'b0;
    cur_vec = '0;
    cur_vec[cfg_q.m] = cur_bit;
    w = {1'b0, dp_q.sreg} | cur_vec;
  end

  conv_enc_parity u_parity (
    .w     (w),
    .p_cnt (cfg_q.p),
    .polys (cfg_q.polys),
    .word  (par_word)
  );

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i)       state_q <= S_IDLE;
    else if (rst_sync_i) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // L=0 detours through CAP so done lands one cycle later without a read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (frame_start_i) state_d = (infobit_length_i == '0) ? S_CAP : S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = (dp_q.bits_left == '0) ? S_DONE : S_BIT;
      S_BIT: begin
        if (dp_q.bits_left == 12'd1) begin
          if (dp_q.prime)   state_d = S_RD;
          else if (cfg_q.tb) state_d = S_DONE;
          else              state_d = S_TAIL;
        end else if (dp_q.bit_idx == 3'd7) begin
          state_d = S_RD;
        end
      end
      S_TAIL: if (dp_q.tail_left == 3'd1) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_d = cfg_q;
    dp_d  = dp_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          cfg_d.m         = decode_m(register_num_i);
          cfg_d.p         = decode_p(valid_polynomials_i);
          cfg_d.tb        = tail_biting_en_i;
          cfg_d.polys     = {polynomial6_i, polynomial5_i, polynomial4_i,
                             polynomial3_i, polynomial2_i, polynomial1_i};
          cfg_d.len       = infobit_length_i;
          cfg_d.src_start = src_start_addr_i;
          dp_d            = '0;
          dp_d.src_addr   = src_start_addr_i;
          dp_d.dst_addr   = dst_start_addr_i;
          dp_d.bits_left  = infobit_length_i;
          dp_d.prime      = tail_biting_en_i;
        end
      end
      S_RD:  dp_d.src_addr = dp_q.src_addr + SRC_ADDR_W'(1);
      S_CAP: begin
        dp_d.byte_val = src_rdata_i;
        dp_d.bit_idx  = 3'd0;
      end
      S_BIT: begin
        dp_d.sreg      = w[MAX_M:1];
        dp_d.bit_idx   = dp_q.bit_idx + 3'd1;
        dp_d.bits_left = dp_q.bits_left - 12'd1;
        if (!dp_q.prime) dp_d.dst_addr = dp_q.dst_addr + DST_ADDR_W'(1);
        // Prime pass done: keep the register, rewind for the encode pass.
        if (dp_q.bits_left == 12'd1) begin
          if (dp_q.prime) begin
            dp_d.prime     = 1'b0;
            dp_d.bits_left = cfg_q.len;
            dp_d.src_addr  = cfg_q.src_start;
          end else if (!cfg_q.tb) begin
            dp_d.tail_left = cfg_q.m;
          end
        end
      end
      S_TAIL: begin
        dp_d.sreg      = w[MAX_M:1];
        dp_d.dst_addr  = dp_q.dst_addr + DST_ADDR_W'(1);
        dp_d.tail_left = dp_q.tail_left - 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      cfg_q <= '0;
      dp_q  <= '0;
    end else if (rst_sync_i) begin
      cfg_q <= '0;
      dp_q  <= '0;
    end else begin
      cfg_q <= cfg_d;
      dp_q  <= dp_d;
    end
  end

  // Source read: src_rd_o high for one cycle, src_rdata_i sampled in CAP.
  always_comb begin
    src_rd_o     = (state_q == S_RD);
    src_addr_o   = dp_q.src_addr;
    dst_wr_o     = ((state_q == S_BIT) && !dp_q.prime) || (state_q == S_TAIL);
    dst_addr_o   = dp_q.dst_addr;
    dst_wdata_o  = dst_wr_o ? par_word : 24'h0;
    frame_done_o = (state_q == S_DONE);
    busy_o       = (state_q == S_RD) || (state_q == S_CAP) ||
                   (state_q == S_BIT) || (state_q == S_TAIL);
    state_o      = state_q;
  end

endmodule

// File: tb/tb_conv_encoder_core.sv
// Directed bench for conv_encoder_core: vector table with an encoder model
// plus hand sequences for abort, start-while-busy and reset.
module tb_conv_encoder_core;
  import viterbi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_an_i, rst_sync_i, frame_start_i, tail_biting_en_i;
  logic [1:0]  register_num_i;
  logic [2:0]  valid_polynomials_i;
  logic [7:0]  polynomial1_i, polynomial2_i, polynomial3_i;
  logic [7:0]  polynomial4_i, polynomial5_i, polynomial6_i;
  logic [11:0] infobit_length_i, src_start_addr_i, dst_start_addr_i;
  logic        frame_done_o, busy_o, src_rd_o, dst_wr_o;
  logic [11:0] src_addr_o, dst_addr_o;
  logic [7:0]  src_rdata_i;
  logic [23:0] dst_wdata_o;
  enc_state_e  state_o;

  always #5 clk_i = ~clk_i;

  conv_encoder_core #(.SRC_ADDR_W(12), .DST_ADDR_W(12)) dut (
    .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
    .frame_start_i(frame_start_i), .register_num_i(register_num_i),
    .valid_polynomials_i(valid_polynomials_i), .tail_biting_en_i(tail_biting_en_i),
    .polynomial1_i(polynomial1_i), .polynomial2_i(polynomial2_i),
    .polynomial3_i(polynomial3_i), .polynomial4_i(polynomial4_i),
    .polynomial5_i(polynomial5_i), .polynomial6_i(polynomial6_i),
    .infobit_length_i(infobit_length_i), .src_start_addr_i(src_start_addr_i),
    .dst_start_addr_i(dst_start_addr_i), .frame_done_o(frame_done_o),
    .busy_o(busy_o), .src_rd_o(src_rd_o), .src_addr_o(src_addr_o),
    .src_rdata_i(src_rdata_i), .dst_wr_o(dst_wr_o), .dst_addr_o(dst_addr_o),
    .dst_wdata_o(dst_wdata_o), .state_o(state_o)
  );

  // Source SRAM: data valid the cycle after the read strobe
  logic [7:0] mem [4096];
  always @(posedge clk_i) if (src_rd_o === 1'b1) src_rdata_i <= mem[src_addr_o];

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [23:0] wr_data_q[$];
  logic [11:0] wr_addr_q[$];
  int          wr_cyc_q[$];
  logic [11:0] rd_addr_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(negedge clk_i) begin
    if (dst_wr_o === 1'b1) begin
      wr_data_q.push_back(dst_wdata_o);
      wr_addr_q.push_back(dst_addr_o);
      wr_cyc_q.push_back(cyc);
    end
    if (src_rd_o === 1'b1) rd_addr_q.push_back(src_addr_o);
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit              tb;
    logic [1:0]      rn;
    logic [2:0]      vp;
    int              len;
    logic [11:0]     src;
    logic [11:0]     dst;
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [5:0][7:0] polys;
    int              exp_wr;
    int              exp_rd;
    logic [23:0]     exp_w0;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input bit tb, input logic [1:0] rn, input logic [2:0] vp,
                              input int len, input logic [11:0] src, input logic [11:0] dst,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [47:0] polys, input int exp_wr, input int exp_rd,
                              input logic [23:0] exp_w0);
    vec_t v;
    v.tb = tb; v.rn = rn; v.vp = vp; v.len = len; v.src = src; v.dst = dst;
    v.b0 = b0; v.b1 = b1; v.polys = polys;
    v.exp_wr = exp_wr; v.exp_rd = exp_rd; v.exp_w0 = exp_w0;
    return v;
  endfunction

  // Reference encoder: input stream (prime+encode or data+zero tail), register starts at 0
  function automatic void build_model(input vec_t v);
    int m, p, t0, n;
    bit seq[$];
    bit par;
    logic [23:0] word;
    exp_q.delete();
    m = 6 - int'(v.rn);
    p = (v.vp > 3'd4) ? 6 : int'(v.vp) + 2;
    for (int i = 0; i < v.len; i++) seq.push_back((i < 8) ? v.b0[i] : v.b1[i-8]);
    if (v.tb) begin
      for (int i = 0; i < v.len; i++) seq.push_back(seq[i]);
      t0 = v.len; n = v.len;
    end else begin
      for (int k = 0; k < m; k++) seq.push_back(1'b0);
      t0 = 0; n = (v.len == 0) ? 0 : v.len + m;
    end
    for (int t = t0; t < t0 + n; t++) begin
      word = '0;
      for (int j = 0; j < p; j++) begin
        par = 1'b0;
        for (int k = 0; k <= m; k++)
          if (t - k >= 0) par ^= v.polys[j][m-k] & seq[t-k];
        word[4*j +: 4] = par ? 4'h9 : 4'h7;
      end
      exp_q.push_back(word);
    end
  endfunction

  task automatic load_mem(input vec_t v);
    mem[v.src] = v.b0;
    mem[12'(v.src + 12'd1)] = v.b1;
  endtask

  task automatic drive_cfg(input vec_t v);
    tail_biting_en_i    = v.tb;
    register_num_i      = v.rn;
    valid_polynomials_i = v.vp;
    infobit_length_i    = 12'(v.len);
    src_start_addr_i    = v.src;
    dst_start_addr_i    = v.dst;
    polynomial1_i = v.polys[0]; polynomial2_i = v.polys[1]; polynomial3_i = v.polys[2];
    polynomial4_i = v.polys[3]; polynomial5_i = v.polys[4]; polynomial6_i = v.polys[5];
  endtask

  // Config inputs are scrambled after acceptance; the DUT must use the latched copy
  task automatic start_frame(input vec_t v);
    @(negedge clk_i);
    drive_cfg(v);
    frame_start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_cyc = cyc;
    frame_start_i = 1'b0;
    tail_biting_en_i    = 1'($urandom_range(0, 1));
    register_num_i      = 2'($urandom_range(0, 3));
    valid_polynomials_i = 3'($urandom_range(0, 7));
    infobit_length_i    = 12'($urandom_range(0, 4095));
    src_start_addr_i    = 12'($urandom_range(0, 4095));
    dst_start_addr_i    = 12'($urandom_range(0, 4095));
    polynomial1_i = 8'($urandom_range(0, 255)); polynomial2_i = 8'($urandom_range(0, 255));
    polynomial3_i = 8'($urandom_range(0, 255)); polynomial4_i = 8'($urandom_range(0, 255));
    polynomial5_i = 8'($urandom_range(0, 255)); polynomial6_i = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input string tag, input int db);
    int budget;
    budget = 3000;
    while (done_cnt == db && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'(done_cnt - db), 32'd1);
    repeat (4) @(posedge clk_i);
  endtask

  task automatic compare_frame(input string tag, input vec_t v, input int wb, input int rb, input int db);
    int nw, nr, nb;
    build_model(v);
    nw = wr_data_q.size() - wb;
    nr = rd_addr_q.size() - rb;
    nb = (v.len + 7) / 8;
    check({tag, "_writes"}, 32'(nw), 32'(v.exp_wr));
    check({tag, "_reads"}, 32'(nr), 32'(v.exp_rd));
    check({tag, "_done_cnt"}, 32'(done_cnt - db), 32'd1);
    if (nw > 0) begin
      check({tag, "_word0_hand"}, 32'(wr_data_q[wb]), 32'(v.exp_w0));
      check({tag, "_done_after_last_wr"}, 32'(done_cyc), 32'(wr_cyc_q[wb+nw-1] + 1));
      if (!v.tb) check({tag, "_first_wr_cycle"}, 32'(wr_cyc_q[wb]), 32'(start_cyc + 2));
    end
    if (v.len == 0) check({tag, "_done_cycle_l0"}, 32'(done_cyc), 32'(start_cyc + 1));
    for (int i = 0; i < nw && i < exp_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), 32'(wr_data_q[wb+i]), 32'(exp_q[i]));
      check($sformatf("%s_waddr%0d", tag, i), 32'(wr_addr_q[wb+i]), 32'(12'(v.dst + 12'(i))));
    end
    for (int i = 0; i < nr && nb > 0; i++)
      check($sformatf("%s_raddr%0d", tag, i), 32'(rd_addr_q[rb+i]), 32'(12'(v.src + 12'(i % nb))));
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int wb, rb, db;
    string tag;
    tag = $sformatf("v%0d", idx);
    wb = wr_data_q.size(); rb = rd_addr_q.size(); db = done_cnt;
    load_mem(v);
    start_frame(v);
    wait_done(tag, db);
    compare_frame(tag, v, wb, rb, db);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int wb, rb, db, na, budget;
    vec_t dummy;
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    src_rdata_i = 8'h0;
    rst_an_i = 1'b0; rst_sync_i = 1'b0; frame_start_i = 1'b0;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 48'h0, 0, 0, 0);
    drive_cfg(dummy);

    vecs[0] = mk(0, 2'd0, 3'd0, 8,  12'h000, 12'h010, 8'h01, 8'h00, {32'h0, 8'h79, 8'h5B}, 14, 1, 24'h000099);
    vecs[1] = mk(0, 2'd0, 3'd0, 16, 12'hFFF, 12'h100, 8'h00, 8'h00, {32'h0, 8'h79, 8'h5B}, 22, 2, 24'h000077);
    vecs[2] = mk(1, 2'd0, 3'd0, 8,  12'h040, 12'h200, 8'h80, 8'h00, {32'h0, 8'h79, 8'h5B}, 8,  2, 24'h000097);
    vecs[3] = mk(0, 2'd0, 3'd4, 1,  12'h050, 12'h400, 8'h01, 8'h00, {6{8'h40}},            7,  1, 24'h999999);
    vecs[4] = mk(0, 2'd0, 3'd7, 1,  12'h050, 12'h480, 8'h01, 8'h00, {6{8'h40}},            7,  1, 24'h999999);
    vecs[5] = mk(1, 2'd0, 3'd0, 4,  12'h060, 12'hFFE, 8'h0A, 8'h00, {32'h0, 8'h79, 8'h5B}, 4,  2, 24'h000079);
    vecs[6] = mk(0, 2'd0, 3'd0, 0,  12'h070, 12'h500, 8'h00, 8'h00, {32'h0, 8'h79, 8'h5B}, 0,  0, 24'h000000);
    vecs[7] = mk(0, 2'd3, 3'd1, 5,  12'h080, 12'h600, 8'h13, 8'h00, {24'h0, 8'h0F, 8'h0D, 8'h0B}, 8, 1, 24'h000999);
    vecs[8] = mk(1, 2'd2, 3'd2, 12, 12'h090, 12'h700, 8'hA5, 8'h03,
                 {16'h0, 8'h1F, 8'h17, 8'h1D, 8'h13}, 12, 4, 24'h009979);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ctrl", {28'h0, busy_o, dst_wr_o, src_rd_o, frame_done_o}, 32'h0);
    check("reset_addrs", {8'h0, src_addr_o, dst_addr_o}, 32'h0);
    check("reset_wdata", 32'(dst_wdata_o), 32'h0);
    check("reset_state", 32'(state_o), 32'(S_IDLE));
    rst_an_i = 1'b1;
    repeat (2) @(posedge clk_i);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Synchronous abort while emitting bits
    wb = wr_data_q.size(); db = done_cnt;
    load_mem(vecs[1]);
    start_frame(vecs[1]);
    budget = 200;
    @(negedge clk_i);
    while (!(state_o == S_BIT && wr_data_q.size() - wb >= 3) && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    check("abort_reach_bit", 32'(state_o), 32'(S_BIT));
    rst_sync_i = 1'b1;
    @(negedge clk_i);
    rst_sync_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_wr", 32'(dst_wr_o), 32'd0);
    check("abort_state", 32'(state_o), 32'(S_IDLE));
    na = wr_data_q.size();
    repeat (20) @(posedge clk_i);
    check("abort_no_more_writes", 32'(wr_data_q.size()), 32'(na));
    check("abort_no_done", 32'(done_cnt), 32'(db));

    // Start pulse while busy must be ignored
    wb = wr_data_q.size(); rb = rd_addr_q.size(); db = done_cnt;
    load_mem(vecs[0]);
    start_frame(vecs[0]);
    repeat (5) @(negedge clk_i);
    drive_cfg(vecs[2]);
    frame_start_i = 1'b1;
    @(negedge clk_i);
    frame_start_i = 1'b0;
    wait_done("busy", db);
    compare_frame("busy", vecs[0], wb, rb, db);
    repeat (10) @(posedge clk_i);
    check("busy_no_second_frame", 32'(done_cnt - db), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
